// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch-request generator. It picks the next fetch address from
// trap, jump, return-address stack or sequential step, and presents it to the ROM over valid/ready.
module pc_fetch_ctrl #(
  parameter int ADDR_W     = 6,
  parameter int STEP       = 5,
  parameter int RESET_ADDR = 0,
  parameter int RAS_DEPTH  = 4,
  localparam int PW        = $clog2(RAS_DEPTH)
) (
  input  logic              clk,
  input  logic              resetIn,
  input  logic              enable,
  input  logic              jumpEn,
  input  logic [ADDR_W-1:0] addrJump,
  input  logic              callEn,
  input  logic              retEn,
  input  logic              trapEn,
  input  logic [ADDR_W-1:0] trapAddr,
  input  logic              haltIn,
  input  logic              resumeIn,
  input  logic              fetchReady,
  output logic [ADDR_W-1:0] addrOut,
  output logic              fetchValid,
  output logic [PW:0]       rasCount,
  output logic              rasUnderflow,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] RESET_A = ADDR_W'(RESET_ADDR);
  localparam logic [PW:0]       FULL    = (PW+1)'(RAS_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]     ras_ptr;
  logic [ADDR_W-1:0] ras_top;
  logic              push, pop, unf_set;

  assign addr_inc = addrOut + STEP_A;
  assign ras_top  = ras_mem[ras_ptr - 1'b1];
  assign halted   = (state == HALT);

  always_comb begin
    state_nxt = state;
    addr_nxt  = addrOut;
    push      = 1'b0;
    pop       = 1'b0;
    unf_set   = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (trapEn) begin
          addr_nxt = trapAddr;
        end else if (!enable) begin
          addr_nxt = addrOut;
        end else if (haltIn) begin
          state_nxt = HALT;
        end else if (jumpEn) begin
          addr_nxt = addrJump;
          push     = callEn;
        end else if (retEn) begin
          if (rasCount == '0) begin
            addr_nxt = addr_inc;
            unf_set  = 1'b1;
          end else begin
            addr_nxt = ras_top;
            pop      = 1'b1;
          end
        end else if (fetchValid && fetchReady) begin
          addr_nxt = addr_inc;
        end
      end
      HALT: begin
        if (trapEn) begin
          addr_nxt  = trapAddr;
          state_nxt = RUN;
        end else if (enable && resumeIn) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetIn) begin
      state        <= BOOT;
      addrOut      <= RESET_A;
      fetchValid   <= 1'b0;
      ras_ptr      <= '0;
      rasCount     <= '0;
      rasUnderflow <= 1'b0;
    end else begin
      state        <= state_nxt;
      addrOut      <= addr_nxt;
      fetchValid   <= (state_nxt == RUN);
      rasUnderflow <= rasUnderflow | unf_set;
      // Circular stack: a push while full overwrites the oldest slot and the count saturates.
      if (push) begin
        ras_ptr  <= ras_ptr + 1'b1;
        rasCount <= (rasCount == FULL) ? rasCount : rasCount + 1'b1;
      end else if (pop) begin
        ras_ptr  <= ras_ptr - 1'b1;
        rasCount <= rasCount - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !resetIn) ras_mem[ras_ptr] <= addr_inc;
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: a queue-based reference model predicts every
// registered output, and a monitor compares the DUT after each clock edge.
module tb_pc_fetch_ctrl;
  localparam int ADDR_W = 6, STEP = 5, RESET_ADDR = 0, RAS_DEPTH = 4;
  localparam int MODN = 1 << ADDR_W;

  logic clk = 0;
  logic resetIn, enable, jumpEn, callEn, retEn, trapEn, haltIn, resumeIn, fetchReady;
  logic [ADDR_W-1:0] addrJump, trapAddr, addrOut;
  logic fetchValid, rasUnderflow, halted;
  logic [2:0] rasCount;

  pc_fetch_ctrl #(.ADDR_W(ADDR_W), .STEP(STEP), .RESET_ADDR(RESET_ADDR), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .resetIn(resetIn), .enable(enable), .jumpEn(jumpEn), .addrJump(addrJump),
    .callEn(callEn), .retEn(retEn), .trapEn(trapEn), .trapAddr(trapAddr), .haltIn(haltIn),
    .resumeIn(resumeIn), .fetchReady(fetchReady), .addrOut(addrOut), .fetchValid(fetchValid),
    .rasCount(rasCount), .rasUnderflow(rasUnderflow), .halted(halted));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              vld;
    logic [2:0]        cnt;
    logic              unf;
    logic              hlt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0, miscompares = 0;

  // Reference model: mode 0=boot, 1=run, 2=halt; RAS as a bounded queue (back = top).
  int m_mode = 0, m_addr = RESET_ADDR;
  int m_ras[$];
  bit m_unf = 0;

  function automatic int nxt(int a);
    return (a + STEP) % MODN;
  endfunction

  task automatic model_step();
    if (resetIn) begin
      m_mode = 0; m_addr = RESET_ADDR; m_ras.delete(); m_unf = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (trapEn) m_addr = trapAddr;
      else if (!enable) ;
      else if (haltIn) m_mode = 2;
      else if (jumpEn) begin
        if (callEn) begin
          m_ras.push_back(nxt(m_addr));
          if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end
        m_addr = addrJump;
      end else if (retEn) begin
        if (m_ras.size() == 0) begin m_unf = 1; m_addr = nxt(m_addr); end
        else m_addr = m_ras.pop_back();
      end else if (fetchReady) m_addr = nxt(m_addr);
    end else begin
      if (trapEn) begin m_addr = trapAddr; m_mode = 1; end
      else if (enable && resumeIn) m_mode = 1;
    end
  endtask

  task automatic step();
    exp_t e;
    model_step();
    e.addr = ADDR_W'(m_addr);
    e.vld  = (m_mode == 1);
    e.cnt  = 3'(m_ras.size());
    e.unf  = m_unf;
    e.hlt  = (m_mode == 2);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    resetIn = 0; enable = 1; jumpEn = 0; callEn = 0; retEn = 0; trapEn = 0;
    haltIn = 0; resumeIn = 0; fetchReady = 1; addrJump = '0; trapAddr = '0;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e, a;
      e = exp_q.pop_front();
      a = '{addr: addrOut, vld: fetchValid, cnt: rasCount, unf: rasUnderflow, hlt: halted};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs @%0t: got addr=%0d vld=%b cnt=%0d unf=%b hlt=%b, want addr=%0d vld=%b cnt=%0d unf=%b hlt=%b",
                 $time, a.addr, a.vld, a.cnt, a.unf, a.hlt, e.addr, e.vld, e.cnt, e.unf, e.hlt);
      end
    end
  end

  initial begin
    idle();
    // Reset then sequential fetch.
    resetIn = 1; step(); step(); resetIn = 0;
    repeat (3) step();
    // Stall the ROM at addrOut=10.
    fetchReady = 0; repeat (3) step(); fetchReady = 1;
    step(); step();
    // Call from 20 to 40, a few steps, then return to 25.
    jumpEn = 1; callEn = 1; addrJump = 40; step(); jumpEn = 0; callEn = 0;
    step(); retEn = 1; step(); retEn = 0; step();
    // Five calls overflow the 4-deep stack, five returns end in underflow.
    for (int i = 0; i < 5; i++) begin
      jumpEn = 1; callEn = 1; addrJump = ADDR_W'(8 * i + 3); step();
    end
    jumpEn = 0; callEn = 0; retEn = 1;
    repeat (5) step();
    retEn = 0; step();
    // Walk to 60 and wrap, then trap under stall with a competing jump.
    jumpEn = 1; addrJump = 60; step(); jumpEn = 0;
    step(); step();
    enable = 0; trapEn = 1; jumpEn = 1; addrJump = 7; trapAddr = 33; step();
    idle(); step();
    // Halt, ignored jumps, resume, and reset from halt.
    haltIn = 1; step(); haltIn = 0;
    jumpEn = 1; addrJump = 11; repeat (2) step(); jumpEn = 0;
    resumeIn = 1; step(); resumeIn = 0; step();
    haltIn = 1; step(); haltIn = 0; step();
    resetIn = 1; step(); resetIn = 0; step(); step();

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      resetIn    = ($urandom_range(0, 299) == 0);
      enable     = ($urandom_range(0, 7) != 0);
      trapEn     = ($urandom_range(0, 24) == 0);
      jumpEn     = ($urandom_range(0, 5) == 0);
      callEn     = $urandom_range(0, 1);
      retEn      = ($urandom_range(0, 4) == 0);
      haltIn     = ($urandom_range(0, 29) == 0);
      resumeIn   = ($urandom_range(0, 3) == 0);
      fetchReady = ($urandom_range(0, 3) != 0);
      addrJump   = ADDR_W'($urandom_range(0, MODN - 1));
      trapAddr   = ADDR_W'($urandom_range(0, MODN - 1));
      step();
    end
    idle(); step();

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
